// File: rtl/uart_pkg.sv
// Shared types and constants for the fabric UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVS       = 16;
  localparam int MID       = 8;
  localparam int DATA_BITS = 8;

  // Clocks per oversample tick, truncated toward zero.
  function automatic int ovs_div(input int clk_hz, input int baud);
    return clk_hz / (OVS * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with a registered head word and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; emptiness is tracked by count, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Head register: next entry after a pop, or the new word when it lands in an empty FIFO.
      if (do_pop)
        pop_data <= (count == (AW+1)'(1)) ? push_data : mem[rd_ptr + AW'(1)];
      else if (do_push && empty)
        pop_data <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a FWFT byte FIFO with valid/ready pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVS_DIV    = ovs_div(CLK_HZ, BAUD),
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        uart_txd,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  output logic                        framing_err,
  output logic                        overrun_err
);

  localparam int TW = $clog2(OVS_DIV + 1);

  logic [1:0]     sync_q, sync_live;
  logic           rxs, armed;
  rx_state_t      state, next_state;
  logic [TW-1:0]  tick_cnt;
  logic           tick;
  logic [3:0]     ovs_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           sample, push_req, frame_bad;
  logic           fifo_full, fifo_empty, pop_eff;

  // NOTE: non-blocking assignments let both flops sample the previous value, forming a true 2-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      sync_live <= 2'b00;
    end else begin
      sync_q    <= {sync_q[0], uart_txd};
      sync_live <= {sync_live[0], 1'b1};
    end
  end
  assign rxs = sync_q[1];

  // Only arm on a high that really came from the pin, not the synchronizer's reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) armed <= 1'b0;
    else if (rxs && sync_live[1]) armed <= 1'b1;
  end

  assign tick = (tick_cnt == TW'(OVS_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     tick_cnt <= '0;
    else if (state == IDLE && next_state == START) tick_cnt <= '0;
    else if (tick)                                 tick_cnt <= '0;
    else                                           tick_cnt <= tick_cnt + TW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (armed && !rxs) next_state = START;
      START: if (sample) next_state = rxs ? IDLE : DATA;
      DATA:  if (sample && bit_idx == 3'(DATA_BITS - 1)) next_state = STOP;
      STOP:  if (sample) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    sample    = 1'b0;
    push_req  = 1'b0;
    frame_bad = 1'b0;
    unique case (state)
      START:      sample = tick && (ovs_cnt == 4'(MID - 1));
      DATA, STOP: sample = tick && (ovs_cnt == 4'(OVS - 1));
      default:    sample = 1'b0;
    endcase
    if (state == STOP && sample) begin
      push_req  = rxs;
      frame_bad = !rxs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovs_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (state == IDLE) begin
      ovs_cnt <= '0;
      bit_idx <= '0;
    end else if (sample) begin
      ovs_cnt <= '0;
      if (state == DATA) begin
        shift[bit_idx] <= rxs;
        bit_idx        <= bit_idx + 3'd1;
      end
    end else if (tick) begin
      ovs_cnt <= ovs_cnt + 4'd1;
    end
  end

  assign rx_valid = !fifo_empty;
  assign pop_eff  = rx_valid && rx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      overrun_err <= push_req && fifo_full && !pop_eff;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (shift),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at a scaled-down line rate (4 clocks per oversample tick).
module tb_uart_rx_fifo;

  localparam int CLK_HZ  = 7_372_800;
  localparam int BAUD    = 115_200;
  localparam int DIV     = CLK_HZ / (16 * BAUD);
  localparam int BIT     = 16 * DIV;
  localparam int DEPTH   = 16;
  localparam int LAT_MIN = BIT * 19 / 2;
  localparam int LAT_MAX = LAT_MIN + 8;
  // Stop-bit sample cycle, counted from the negedge that drives the start edge:
  // 2 synchronizer cycles + 9.5 bit times.
  localparam int STOP_SAMPLE = 2 + 8 * DIV + 9 * BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_txd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rx_count;
  logic       framing_err, overrun_err;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .uart_txd    (uart_txd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_count    (rx_count),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   fe_cnt = 0, oe_cnt = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;
  int   tests = 0, fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Error pulses are counted per high cycle, so a stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (framing_err === 1'b1) fe_cnt++;
    if (overrun_err === 1'b1) oe_cnt++;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    uart_txd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int start_cyc);
    @(negedge clk);
    start_cyc = cyc;
    uart_txd  = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_txd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_txd = stop_ok;
    repeat (stop_ok ? BIT : BIT * 3 / 4) @(negedge clk);
    uart_txd = 1'b1;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, " valid"}, rx_valid, 1);
    check({name, " data"}, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_fe;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  int st, fe0, oe0;

  initial begin
    vecs[0] = '{data: 8'hA5, stop_ok: 1'b1, exp_fe: 0, exp_valid: 1'b1, exp_data: 8'hA5};
    vecs[1] = '{data: 8'h81, stop_ok: 1'b0, exp_fe: 1, exp_valid: 1'b0, exp_data: 8'h00};
    vecs[2] = '{data: 8'h42, stop_ok: 1'b1, exp_fe: 0, exp_valid: 1'b1, exp_data: 8'h42};
    vecs[3] = '{data: 8'h00, stop_ok: 1'b1, exp_fe: 0, exp_valid: 1'b1, exp_data: 8'h00};
    vecs[4] = '{data: 8'hFF, stop_ok: 1'b1, exp_fe: 0, exp_valid: 1'b1, exp_data: 8'hFF};
    vecs[5] = '{data: 8'h7E, stop_ok: 1'b0, exp_fe: 1, exp_valid: 1'b0, exp_data: 8'h00};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset rx_valid", rx_valid, 0);
    check("reset rx_count", rx_count, 0);
    check("reset rx_data", rx_data, 0);
    check("reset framing_err", framing_err, 0);
    check("reset overrun_err", overrun_err, 0);
    reset = 1'b0;
    idle(20);

    // Table: single frames, each popped before the next
    for (int i = 0; i < NV; i++) begin
      fe0 = fe_cnt;
      oe0 = oe_cnt;
      rise_cyc = 0;
      send_frame(vecs[i].data, vecs[i].stop_ok, st);
      idle(2 * BIT);
      check($sformatf("vec%0d framing pulses", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d overrun pulses", i), oe_cnt - oe0, 0);
      check($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d rx_count", i), rx_count, vecs[i].exp_valid ? 1 : 0);
      if (vecs[i].exp_valid) begin
        check_range($sformatf("vec%0d latency", i), rise_cyc - st, LAT_MIN, LAT_MAX);
        pop_expect($sformatf("vec%0d pop", i), vecs[i].exp_data);
        check($sformatf("vec%0d empty after pop", i), rx_valid, 0);
      end
    end

    // Short low glitch on an idle line, then a real frame
    fe0 = fe_cnt;
    uart_txd = 1'b0;
    repeat (BIT * 3 / 8) @(negedge clk);
    idle(2 * BIT);
    check("glitch rx_valid", rx_valid, 0);
    check("glitch framing pulses", fe_cnt - fe0, 0);
    send_frame(8'h3C, 1'b1, st);
    idle(BIT);
    check("after glitch rx_count", rx_count, 1);
    pop_expect("after glitch", 8'h3C);

    // 17 back-to-back frames into a 16-deep FIFO
    oe0 = oe_cnt;
    for (int b = 0; b < 17; b++) begin
      send_frame(8'(b), 1'b1, st);
      if (b == 15) begin
        check("fill16 rx_count", rx_count, 16);
        check("fill16 overrun pulses", oe_cnt - oe0, 0);
      end
    end
    idle(BIT);
    check("fill17 rx_count", rx_count, 16);
    check("fill17 overrun pulses", oe_cnt - oe0, 1);

    // Full FIFO, pop exactly in the stop-sample cycle of 0x55: no overrun
    oe0 = oe_cnt;
    fe0 = fe_cnt;
    fork
      send_frame(8'h55, 1'b1, st);
      begin
        @(negedge clk);
        repeat (STOP_SAMPLE) @(negedge clk);
        check("full pop head", rx_data, 8'h00);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(BIT);
    check("full pop rx_count", rx_count, 16);
    check("full pop overrun pulses", oe_cnt - oe0, 0);
    check("full pop framing pulses", fe_cnt - fe0, 0);
    for (int j = 1; j < 16; j++) pop_expect($sformatf("drain%0d", j), 8'(j));
    check("last entry data", rx_data, 8'h55);
    check("last entry count", rx_count, 1);

    // Reset mid-DATA of 0xF0, released while the line is still low
    fe0 = fe_cnt;
    oe0 = oe_cnt;
    fork
      send_frame(8'hF0, 1'b1, st);
      begin
        @(negedge clk);
        repeat (2 * BIT + BIT / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid-frame reset rx_count", rx_count, 0);
        check("mid-frame reset rx_valid", rx_valid, 0);
        repeat (10) @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(2 * BIT);
    check("post-reset rx_valid", rx_valid, 0);
    check("post-reset rx_count", rx_count, 0);
    check("post-reset framing pulses", fe_cnt - fe0, 0);
    check("post-reset overrun pulses", oe_cnt - oe0, 0);

    rise_cyc = 0;
    send_frame(8'h99, 1'b1, st);
    idle(BIT);
    check("0x99 rx_count", rx_count, 1);
    check_range("0x99 latency", rise_cyc - st, LAT_MIN, LAT_MAX);
    pop_expect("0x99", 8'h99);
    check("final framing pulses", fe_cnt - fe0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
